// File: rtl/booth_r4_seq_mul_if.sv
// Operand/product valid-ready bundle for the radix-4 Booth multiplier.
// master = operand producer / result consumer side, slave = multiplier side.
interface booth_r4_seq_mul_if #(
    parameter int W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier: one Booth group per RUN cycle, W/2 cycles per product.
// Signed 2W-bit result is held in DONE until the consumer takes it.
module booth_r4_seq_mul #(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst,
    booth_r4_seq_mul_if.slave   bus,
    output logic                busy,
    output logic [2:0]          grp_dbg
);
    localparam int NGRP = W / 2;
    localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [CW-1:0] LAST = CW'(NGRP - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   xr;
    logic [W:0]     ysh;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  cnt;

    logic [2:0]     g;
    logic [W:0]     pp;
    logic           cout;
    logic [2*W-1:0] term;
    logic [2*W-1:0] addend;

    // y is latched with a zero appended below bit 0 (the y[-1] term) and shifted
    // right two bits per group, so the current group always sits in ysh[2:0].
    assign g = ysh[2:0];

    always_comb begin
        pp   = '0;
        cout = 1'b0;
        case (g)
            3'b001, 3'b010: pp = {xr[W-1], xr};
            3'b011:         pp = {xr, 1'b0};
            3'b100: begin
                pp   = {~xr, 1'b1};
                cout = 1'b1;
            end
            3'b101, 3'b110: begin
                pp   = {~xr[W-1], ~xr};
                cout = 1'b1;
            end
            default: ;
        endcase
    end

    assign term   = {{(W-1){pp[W]}}, pp} + {{(2*W-1){1'b0}}, cout};
    assign addend = term << {cnt, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        bus.out_valid = 1'b0;
        busy         = 1'b1;
        grp_dbg      = 3'b000;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                grp_dbg = g;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xr  <= '0;
            ysh <= '0;
            acc <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    xr  <= bus.x;
                    ysh <= {bus.y, 1'b0};
                    acc <= '0;
                    cnt <= '0;
                end
                RUN: begin
                    acc <= acc + addend;
                    ysh <= ysh >> 2;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.product = acc;
endmodule
